// File: rtl/axis_expect_checker_if.sv
// AXI-Stream bundle shared by a stream source, its sink and passive taps.
// The checker attaches through the monitor modport and never drives the bus.
interface axis_expect_checker_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master  (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave   (input tdata, tkeep, tvalid, tlast, output tready);
  modport monitor (input tdata, tkeep, tvalid, tready, tlast);
endinterface

// File: rtl/axis_expect_checker.sv
// Passive AXI-Stream packet checker against a programmable expected-beat table.
// Optional timeout watchdog is enabled by defining AXIS_CHECKER_TIMEOUT_EN.
module axis_expect_checker #(
  parameter int C_AXIS_DATA_WIDTH = 512,
  parameter int KEEP_WIDTH        = C_AXIS_DATA_WIDTH / 8,
  parameter int DEPTH             = 4,
  parameter int CNT_WIDTH         = 16,
  parameter int ONESHOT           = 1,
  parameter int TIMEOUT_CYCLES    = 10000,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  axis_expect_checker_if.monitor        axis,
  input  logic                          exp_wr_en,
  input  logic [AW-1:0]                 exp_wr_addr,
  input  logic [C_AXIS_DATA_WIDTH-1:0]  exp_wr_data,
  input  logic [KEEP_WIDTH-1:0]         exp_wr_mask,
  input  logic [KEEP_WIDTH-1:0]         exp_wr_keep,
  input  logic [LW-1:0]                 exp_len,
  input  logic                          arm,
  output logic                          armed,
  output logic                          detected,
  output logic                          match_pulse,
  output logic                          mismatch_pulse,
  output logic [CNT_WIDTH-1:0]          match_count,
  output logic [CNT_WIDTH-1:0]          mismatch_count,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic                          timeout
);

  typedef enum logic [2:0] {IDLE, HUNT, MATCH, SKIP, DONE} state_e;

  state_e                 state_q;
  logic                   in_pkt_q;
  logic [AW-1:0]          idx_q;
  logic [LW-1:0]          len_q;
  logic                   detected_q;
  logic                   match_pulse_q;
  logic                   mismatch_pulse_q;
  logic [CNT_WIDTH-1:0]   match_cnt_q;
  logic [CNT_WIDTH-1:0]   mismatch_cnt_q;
  logic [CNT_WIDTH-1:0]   pkt_cnt_q;

  logic [C_AXIS_DATA_WIDTH-1:0] tbl_data_q [DEPTH];
  logic [KEEP_WIDTH-1:0]        tbl_mask_q [DEPTH];
  logic [KEEP_WIDTH-1:0]        tbl_keep_q [DEPTH];

  always_ff @(posedge clk) begin
    if (exp_wr_en && (32'(exp_wr_addr) < 32'(DEPTH))) begin
      tbl_data_q[exp_wr_addr] <= exp_wr_data;
      tbl_mask_q[exp_wr_addr] <= exp_wr_mask;
      tbl_keep_q[exp_wr_addr] <= exp_wr_keep;
    end
  end

  // idx_q is held at 0 outside MATCH, so HUNT compares entry 0 on the same path.
  logic                  beat;
  logic                  last_idx;
  logic                  beat_ok;
  logic                  decide;
  logic                  full_match;
  logic                  fail;
  logic                  step;
  logic [KEEP_WIDTH-1:0] byte_diff;
  logic [LW-1:0]         arm_len;

  always_comb begin
    byte_diff = '0;
    for (int unsigned b = 0; b < KEEP_WIDTH; b++) begin
      byte_diff[b] = tbl_mask_q[idx_q][b] &
                     (|(axis.tdata[8*b +: 8] ^ tbl_data_q[idx_q][8*b +: 8]));
    end
  end

  assign beat       = axis.tvalid & axis.tready;
  assign last_idx   = (LW'(idx_q) == (len_q - LW'(1)));
  assign beat_ok    = ~(|byte_diff) & (axis.tkeep == tbl_keep_q[idx_q]) &
                      (axis.tlast == last_idx);
  assign decide     = beat & (((state_q == HUNT) & ~in_pkt_q) | (state_q == MATCH));
  assign full_match = decide & beat_ok & last_idx;
  assign fail       = decide & ~beat_ok;
  assign step       = decide & beat_ok & ~last_idx;

  always_comb begin
    arm_len = exp_len;
    if (exp_len == '0) begin
      arm_len = LW'(1);
    end else if (32'(exp_len) > 32'(DEPTH)) begin
      arm_len = LW'(DEPTH);
    end
  end

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

`ifdef AXIS_CHECKER_TIMEOUT_EN
  logic        timeout_q;
  logic [31:0] timer_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      in_pkt_q         <= 1'b0;
      idx_q            <= '0;
      len_q            <= LW'(1);
      detected_q       <= 1'b0;
      match_pulse_q    <= 1'b0;
      mismatch_pulse_q <= 1'b0;
      match_cnt_q      <= '0;
      mismatch_cnt_q   <= '0;
      pkt_cnt_q        <= '0;
`ifdef AXIS_CHECKER_TIMEOUT_EN
      timeout_q        <= 1'b0;
      timer_q          <= '0;
`endif
    end else begin
      match_pulse_q    <= 1'b0;
      mismatch_pulse_q <= 1'b0;
      if (beat) begin
        in_pkt_q <= ~axis.tlast;
      end
      if (arm) begin
        state_q        <= HUNT;
        idx_q          <= '0;
        len_q          <= arm_len;
        detected_q     <= 1'b0;
        match_cnt_q    <= '0;
        mismatch_cnt_q <= '0;
        pkt_cnt_q      <= '0;
`ifdef AXIS_CHECKER_TIMEOUT_EN
        timeout_q      <= 1'b0;
        timer_q        <= '0;
`endif
      end else begin
        if ((state_q == HUNT) && beat && !in_pkt_q) begin
          pkt_cnt_q <= sat_inc(pkt_cnt_q);
        end
        if (full_match) begin
          match_pulse_q <= 1'b1;
          match_cnt_q   <= sat_inc(match_cnt_q);
          detected_q    <= 1'b1;
          idx_q         <= '0;
          state_q       <= (ONESHOT != 0) ? DONE : HUNT;
        end else if (fail) begin
          mismatch_pulse_q <= 1'b1;
          mismatch_cnt_q   <= sat_inc(mismatch_cnt_q);
          idx_q            <= '0;
          state_q          <= axis.tlast ? HUNT : SKIP;
        end else if (step) begin
          idx_q   <= idx_q + AW'(1);
          state_q <= MATCH;
        end else if ((state_q == SKIP) && beat && axis.tlast) begin
          state_q <= HUNT;
        end
`ifdef AXIS_CHECKER_TIMEOUT_EN
        // Overrides any state update above; detected_q is the pre-edge value.
        if ((state_q != IDLE) && !detected_q && !timeout_q) begin
          timer_q <= timer_q + 32'd1;
          if ((timer_q + 32'd1) == 32'(TIMEOUT_CYCLES)) begin
            timeout_q <= 1'b1;
            state_q   <= DONE;
          end
        end
`endif
      end
    end
  end

  assign armed          = (state_q == HUNT) || (state_q == MATCH) || (state_q == SKIP);
  assign detected       = detected_q;
  assign match_pulse    = match_pulse_q;
  assign mismatch_pulse = mismatch_pulse_q;
  assign match_count    = match_cnt_q;
  assign mismatch_count = mismatch_cnt_q;
  assign pkt_count      = pkt_cnt_q;

`ifdef AXIS_CHECKER_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_axis_expect_checker.sv
// Bench for axis_expect_checker: a one-shot and a hunting (4-bit counter)
// instance share one bus and are compared each cycle with a packet-level model.
module tb_axis_expect_checker;
  localparam int DW    = 512;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int TCYC  = 100;
  localparam int NI    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_expect_checker_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

  logic          exp_wr_en   = 1'b0;
  logic [1:0]    exp_wr_addr = '0;
  logic [DW-1:0] exp_wr_data = '0;
  logic [KW-1:0] exp_wr_mask = '0;
  logic [KW-1:0] exp_wr_keep = '0;
  logic [2:0]    exp_len     = 3'd1;
  logic          arm         = 1'b0;

  logic        o_armed0, o_det0, o_mp0, o_mmp0, o_to0;
  logic [15:0] o_mc0, o_mmc0, o_pc0;
  logic        o_armed1, o_det1, o_mp1, o_mmp1, o_to1;
  logic [3:0]  o_mc1, o_mmc1, o_pc1;

  axis_expect_checker #(
    .C_AXIS_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH), .CNT_WIDTH(16),
    .ONESHOT(1), .TIMEOUT_CYCLES(TCYC)
  ) u_one (
    .clk(clk), .rst(rst), .axis(bus),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .exp_wr_mask(exp_wr_mask), .exp_wr_keep(exp_wr_keep), .exp_len(exp_len), .arm(arm),
    .armed(o_armed0), .detected(o_det0), .match_pulse(o_mp0), .mismatch_pulse(o_mmp0),
    .match_count(o_mc0), .mismatch_count(o_mmc0), .pkt_count(o_pc0), .timeout(o_to0)
  );

  axis_expect_checker #(
    .C_AXIS_DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH), .CNT_WIDTH(4),
    .ONESHOT(0), .TIMEOUT_CYCLES(TCYC)
  ) u_hunt (
    .clk(clk), .rst(rst), .axis(bus),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .exp_wr_mask(exp_wr_mask), .exp_wr_keep(exp_wr_keep), .exp_len(exp_len), .arm(arm),
    .armed(o_armed1), .detected(o_det1), .match_pulse(o_mp1), .mismatch_pulse(o_mmp1),
    .match_count(o_mc1), .mismatch_count(o_mmc1), .pkt_count(o_pc1), .timeout(o_to1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: per-packet view (beat position k since SOP), shared table.
  logic [DW-1:0] m_data [DEPTH];
  logic [KW-1:0] m_mask [DEPTH];
  logic [KW-1:0] m_keep [DEPTH];
  int  m_len    = 1;
  bit  m_in_pkt = 1'b0;
  int  cmax    [NI] = '{65535, 15};
  bit  oneshot [NI] = '{1'b1, 1'b0};
  bit  m_active[NI], m_done[NI], m_cand[NI], m_det[NI], m_mp[NI], m_mmp[NI], m_to[NI];
  int  m_k[NI], m_mc[NI], m_mmc[NI], m_pc[NI], m_timer[NI];

  function automatic bit m_beat_ok(input int k);
    if (bus.tkeep !== m_keep[k]) return 1'b0;
    if (bus.tlast !== (k == m_len - 1)) return 1'b0;
    for (int b = 0; b < KW; b++) begin
      if (m_mask[k][b] && (bus.tdata[8*b +: 8] !== m_data[k][8*b +: 8])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_step();
    bit beat;
    bit det_before;
    int l;
    beat = bus.tvalid && bus.tready;
    for (int i = 0; i < NI; i++) begin
      det_before = m_det[i];
      m_mp[i] = 1'b0;
      m_mmp[i] = 1'b0;
      if (rst) begin
        m_active[i] = 1'b0; m_done[i] = 1'b0; m_cand[i] = 1'b0; m_det[i] = 1'b0;
        m_to[i] = 1'b0; m_k[i] = 0; m_mc[i] = 0; m_mmc[i] = 0; m_pc[i] = 0; m_timer[i] = 0;
      end else if (arm) begin
        m_active[i] = 1'b1; m_done[i] = 1'b0; m_cand[i] = 1'b0; m_det[i] = 1'b0;
        m_to[i] = 1'b0; m_k[i] = 0; m_mc[i] = 0; m_mmc[i] = 0; m_pc[i] = 0; m_timer[i] = 0;
      end else begin
        if (m_active[i] && !m_done[i] && beat) begin
          if (!m_in_pkt) begin
            if (m_pc[i] < cmax[i]) m_pc[i]++;
            m_cand[i] = 1'b1;
            m_k[i] = 0;
          end
          if (m_cand[i]) begin
            if (!m_beat_ok(m_k[i])) begin
              m_mmp[i] = 1'b1;
              if (m_mmc[i] < cmax[i]) m_mmc[i]++;
              m_cand[i] = 1'b0;
            end else if (m_k[i] == m_len - 1) begin
              m_mp[i] = 1'b1;
              if (m_mc[i] < cmax[i]) m_mc[i]++;
              m_det[i] = 1'b1;
              m_cand[i] = 1'b0;
              if (oneshot[i]) m_done[i] = 1'b1;
            end else begin
              m_k[i]++;
            end
          end
        end
`ifdef AXIS_CHECKER_TIMEOUT_EN
        if (m_active[i] && !det_before && !m_to[i]) begin
          m_timer[i]++;
          if (m_timer[i] == TCYC) begin
            m_to[i] = 1'b1;
            m_done[i] = 1'b1;
          end
        end
`endif
      end
    end
    if (rst) m_in_pkt = 1'b0;
    else if (beat) m_in_pkt = !bus.tlast;
    if (!rst && arm) begin
      l = int'(exp_len);
      if (l == 0) l = 1;
      if (l > DEPTH) l = DEPTH;
      m_len = l;
    end
    if (exp_wr_en) begin
      m_data[exp_wr_addr] = exp_wr_data;
      m_mask[exp_wr_addr] = exp_wr_mask;
      m_keep[exp_wr_addr] = exp_wr_keep;
    end
  endtask

  task automatic check_all();
    check_eq("u_one.armed",    64'(o_armed0), 64'(m_active[0] && !m_done[0]));
    check_eq("u_one.detected", 64'(o_det0),   64'(m_det[0]));
    check_eq("u_one.match_p",  64'(o_mp0),    64'(m_mp[0]));
    check_eq("u_one.mism_p",   64'(o_mmp0),   64'(m_mmp[0]));
    check_eq("u_one.match_c",  64'(o_mc0),    64'(m_mc[0]));
    check_eq("u_one.mism_c",   64'(o_mmc0),   64'(m_mmc[0]));
    check_eq("u_one.pkt_c",    64'(o_pc0),    64'(m_pc[0]));
    check_eq("u_one.timeout",  64'(o_to0),    64'(m_to[0]));
    check_eq("u_hunt.armed",    64'(o_armed1), 64'(m_active[1] && !m_done[1]));
    check_eq("u_hunt.detected", 64'(o_det1),   64'(m_det[1]));
    check_eq("u_hunt.match_p",  64'(o_mp1),    64'(m_mp[1]));
    check_eq("u_hunt.mism_p",   64'(o_mmp1),   64'(m_mmp[1]));
    check_eq("u_hunt.match_c",  64'(o_mc1),    64'(m_mc[1]));
    check_eq("u_hunt.mism_c",   64'(o_mmc1),   64'(m_mmc[1]));
    check_eq("u_hunt.pkt_c",    64'(o_pc1),    64'(m_pc[1]));
    check_eq("u_hunt.timeout",  64'(o_to1),    64'(m_to[1]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    arm = 1'b0;
    exp_wr_en = 1'b0;
    bus.tvalid = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [DW-1:0] d, input logic [KW-1:0] m,
                    input logic [KW-1:0] k);
    exp_wr_en = 1'b1;
    exp_wr_addr = 2'(addr);
    exp_wr_data = d;
    exp_wr_mask = m;
    exp_wr_keep = k;
    tick();
  endtask

  task automatic do_arm(input int len);
    arm = 1'b1;
    exp_len = 3'(len);
    tick();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last);
    bus.tdata = d;
    bus.tkeep = k;
    bus.tlast = last;
    bus.tvalid = 1'b1;
    bus.tready = 1'b1;
    tick();
  endtask

  // Holds the beat with random backpressure until it is accepted (bounded).
  task automatic send_stall(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit last);
    bit acc;
    int tries = 0;
    do begin
      bus.tdata = d;
      bus.tkeep = k;
      bus.tlast = last;
      bus.tvalid = ($urandom_range(0, 4) != 0) || (tries > 8);
      bus.tready = ($urandom_range(0, 3) != 0) || (tries > 8);
      acc = bus.tvalid && bus.tready;
      tick();
      tries++;
    end while (!acc);
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d, d2, r0, r1, r2, pd;
    logic [KW-1:0] msk, pk;
    int plen, pick, bt;

    bus.tdata = '0; bus.tkeep = '0; bus.tvalid = 1'b0; bus.tready = 1'b1; bus.tlast = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_eq("reset.armed", 64'(o_armed1), 64'd0);
    rst = 1'b0;
    tick();

    // Single-beat packet, full compare
    d = rand_word();
    d[8*58 +: 16] = 16'h0000;
    wr(0, d, '1, '1);
    do_arm(1);
    send(d, '1, 1'b1);
    check_eq("t1.match_p", 64'(o_mp0), 64'd1);
    check_eq("t1.det", 64'(o_det0), 64'd1);
    check_eq("t1.done", 64'(o_armed0), 64'd0);
    tick();
    check_eq("t1.pulse_len", 64'(o_mp0), 64'd0);

    // Byte 59 masked off, byte 58 compared
    msk = '1;
    msk[59] = 1'b0;
    wr(0, d, msk, '1);
    do_arm(1);
    d2 = d;
    d2[8*59 +: 8] = 8'h01;
    send(d2, '1, 1'b1);
    check_eq("t2.masked_match", 64'(o_mp1), 64'd1);
    do_arm(1);
    d2 = d;
    d2[8*58 +: 8] = 8'h01;
    send(d2, '1, 1'b1);
    check_eq("t2.mism_c", 64'(o_mmc0), 64'd1);
    check_eq("t2.det", 64'(o_det0), 64'd0);

    // Three-beat packets: beat 1 wrong, then correct
    r0 = rand_word(); r1 = rand_word(); r2 = rand_word();
    wr(0, r0, '1, '1);
    wr(1, r1, '1, '1);
    wr(2, r2, '1, '1);
    do_arm(3);
    send(r0, '1, 1'b0);
    send(r1 ^ DW'(1), '1, 1'b0);
    send(r2, '1, 1'b1);
    send(r0, '1, 1'b0);
    send(r1, '1, 1'b0);
    send(r2, '1, 1'b1);
    check_eq("t3.match_c", 64'(o_mc1), 64'd1);
    check_eq("t3.mism_c", 64'(o_mmc1), 64'd1);
    check_eq("t3.pkt_c", 64'(o_pc1), 64'd2);

    // Length/tlast and tkeep boundaries
    wr(1, r1, '1, KW'(64'h1F));
    do_arm(2);
    send(r0, '1, 1'b1);
    send(r0, '1, 1'b0);
    send(r1, KW'(64'hFFFFF), 1'b1);
    send(r0, '1, 1'b0);
    send(r1, KW'(64'h1F), 1'b1);
    check_eq("t4.mism_c", 64'(o_mmc1), 64'd2);
    check_eq("t4.match_c", 64'(o_mc1), 64'd1);
    check_eq("t4.pkt_c", 64'(o_pc1), 64'd3);

    // Arm during beat 2 of 3, then a correct packet
    do_arm(3);
    send(r0, '1, 1'b0);
    arm = 1'b1;
    exp_len = 3'd3;
    send(r1, KW'(64'h1F), 1'b0);
    send(r2, '1, 1'b1);
    check_eq("t5.no_sop", 64'(o_pc1), 64'd0);
    send(r0, '1, 1'b0);
    send(r1, KW'(64'h1F), 1'b0);
    send(r2, '1, 1'b1);
    check_eq("t5.match_c", 64'(o_mc1), 64'd1);
    check_eq("t5.pkt_c", 64'(o_pc1), 64'd1);

    // Reset in the middle of a matching packet
    do_arm(3);
    send(r0, '1, 1'b0);
    rst = 1'b1;
    send(r1, KW'(64'h1F), 1'b0);
    rst = 1'b0;
    check_eq("t6.armed", 64'(o_armed1), 64'd0);
    check_eq("t6.pkt_c", 64'(o_pc1), 64'd0);
    check_eq("t6.det", 64'(o_det0), 64'd0);

    // Idle window after arm: timeout only with the watchdog compiled in
    do_arm(3);
    for (int c = 0; c < TCYC - 1; c++) tick();
    check_eq("t7.to_before", 64'(o_to1), 64'd0);
    tick();
`ifdef AXIS_CHECKER_TIMEOUT_EN
    check_eq("t7.to_at", 64'(o_to1), 64'd1);
`else
    check_eq("t7.to_at", 64'(o_to1), 64'd0);
`endif

    // Randomized traffic, table updates, re-arms and resets
    for (int e = 0; e < DEPTH; e++) wr(e, rand_word(), '1, '1);
    do_arm(DEPTH);
    for (int it = 0; it < 400; it++) begin
      pick = $urandom_range(0, 99);
      if (pick < 8) begin
        msk = ($urandom_range(0, 1) == 0) ? '1 : {$urandom, $urandom};
        pk  = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : '1;
        wr($urandom_range(0, DEPTH - 1), rand_word(), msk, pk);
      end else if (pick < 14) begin
        do_arm($urandom_range(0, 7));
      end else if (pick < 16) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        plen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : m_len;
        for (int k = 0; k < plen; k++) begin
          pd = (k < DEPTH) ? m_data[k] : rand_word();
          pk = (k < DEPTH) ? m_keep[k] : '1;
          if ($urandom_range(0, 9) == 0) begin
            bt = $urandom_range(0, DW - 1);
            pd[bt] = ~pd[bt];
          end
          if ($urandom_range(0, 19) == 0) pk[$urandom_range(0, KW - 1)] ^= 1'b1;
          if ($urandom_range(0, 5) == 0) begin
            arm = 1'b1;
            exp_len = 3'($urandom_range(1, DEPTH));
          end
          send_stall(pd, pk, k == plen - 1);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_expect_checker.md
# axis_expect_checker

Synthesizable, parametrised successor to the single-value output check in the RMT wrapper benches. It passively taps an AXI-Stream interface, such as the `rmt_wrapper` master port, and compares each packet against a programmable expected sequence of up to DEPTH beats with per-byte masks. It reports sticky detection, per-packet match/mismatch pulses and saturating counters. It is usable in simulation benches and as an on-chip self-check.

## Interface
- C_AXIS_DATA_WIDTH, 512: tapped tdata width.
- KEEP_WIDTH, C_AXIS_DATA_WIDTH/8: tkeep width and per-byte mask width.
- DEPTH, 4: maximum expected beats per packet; must be ≥1.
- CNT_WIDTH, 16: counter width.
- ONESHOT, 1: 1 = go to DONE after the first full match; 0 = keep hunting.
- TIMEOUT_CYCLES, 10000: timeout window; only used with the macro.

- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- axis_tdata, in, C_AXIS_DATA_WIDTH: tapped data.
- axis_tkeep, in, KEEP_WIDTH: tapped keep.
- axis_tvalid / axis_tready / axis_tlast, in, 1 each: tapped handshake.
- exp_wr_en, in, 1: write one expected-table entry.
- exp_wr_addr, in, $clog2(DEPTH) (min 1): entry index.
- exp_wr_data, in, C_AXIS_DATA_WIDTH: expected tdata.
- exp_wr_mask, in, KEEP_WIDTH: byte compare enable, 1 = compare.
- exp_wr_keep, in, KEEP_WIDTH: expected tkeep.
- exp_len, in, $clog2(DEPTH)+1: beats per expected packet, 1..DEPTH; sampled at arm.
- arm, in, 1: pulse; clears results and starts checking.
- armed, out, 1: state is HUNT, MATCH or SKIP.
- detected, out, 1: sticky; at least one full match since arm.
- match_pulse, out, 1: one cycle per fully matching packet.
- mismatch_pulse, out, 1: one cycle per failing packet.
- match_count / mismatch_count / pkt_count, out, CNT_WIDTH: saturating counters.
- timeout, out, 1: sticky timeout flag.

## Operation
- Beat accepted = axis_tvalid & axis_tready. The tap never drives the bus.
- The in_pkt flag is tracked in every state: set on an accepted beat with tlast=0, cleared on an accepted beat with tlast=1. A beat is start-of-packet (SOP) when in_pkt=0.
- Beat i matches when all of these hold:
  - ((tdata ^ exp_data[i]) & byte-expanded exp_mask[i]) == 0;
  - tkeep == exp_keep[i];
  - tlast == (i == len-1).
- States:
  - IDLE: after reset. arm → HUNT.
  - HUNT: waits for an SOP beat; non-SOP beats are ignored. SOP beat with pkt_count++ → match at i=0:
    - len=1: full match.
    - len>1: MATCH, i=1.
    - mismatch: mismatch_pulse; go to SKIP if tlast=0, else stay in HUNT.
  - MATCH: each accepted beat is compared at index i.
    - Match on i=len-1 → full match.
    - Match otherwise → i++.
    - Mismatch → mismatch_pulse; go to SKIP if tlast=0, else HUNT.
  - SKIP: stays until an accepted tlast beat, then → HUNT.
  - Full match: match_pulse, match_count++, detected=1. Next state is DONE if ONESHOT=1, else HUNT.
  - DONE: counters frozen; only arm or rst leave it.
- arm in any state:
  - clears detected, timeout, counters and i;
  - latches exp_len, with 0 clamped to 1 and values >DEPTH clamped to DEPTH;
  - → HUNT.
  - If arm coincides with an accepted beat, that beat is not compared; in_pkt still updates.
- Table writes are accepted in every state and take effect on the next compared beat. Writes with an out-of-range address are dropped.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values:
  - state IDLE;
  - in_pkt=0;
  - armed, detected, match_pulse, mismatch_pulse and timeout = 0;
  - all counters 0;
  - table contents undefined.
- Result latency: match_pulse, mismatch_pulse, counter updates and detected all take effect on the clock edge after the deciding beat is accepted, i.e. 1 cycle, all registered.
- Pulses are exactly one cycle. Back-to-back single-beat packets can pulse on consecutive cycles.
- rst mid-packet: everything returns to reset values, including in_pkt=0. The next accepted beat is treated as SOP.
- The compare path must be no deeper than one XOR/AND/reduction level before the state register.

## Configuration
- AXIS_CHECKER_TIMEOUT_EN defined:
  - a 32-bit cycle counter starts at arm;
  - if it reaches TIMEOUT_CYCLES with detected=0 and the state is not IDLE, timeout is set (sticky) and the state goes to DONE;
  - the counter stops on detect.
- Not defined: no timer logic; timeout is tied to 0.

## Test plan
- Single-beat packet. len=1; entry0 = D (512-bit value), mask all-ones, keep all-ones. arm, then send D with tlast=1 → match_pulse 1 cycle after accept; detected=1; match_count=1; pkt_count=1; state DONE.
- Masked compare. Entry0 mask = 0 on byte 59; send D with byte 59 altered 0x00→0x01 → match. Alter byte 58 instead → mismatch_pulse, mismatch_count=1, detected=0.
- Multi-beat with a failing packet. len=3, ONESHOT=0. Send a 3-beat packet with beat 1 wrong, then the correct 3-beat packet → mismatch at beat 1, SKIP until tlast, then match; counts match=1, mismatch=1, pkt=2.
- Length/tlast boundary. len=2; send a correct 2-beat packet with tlast on beat 0 → mismatch; a correct packet with tlast on beat 1 but tkeep on beat 1 = 0xFFFFF instead of the expected 0x1F → mismatch.
- Arm/reset mid-packet. Arm during beat 2 of 3 → no compare until the next SOP; the following correct packet matches. rst asserted mid-MATCH → all outputs 0 the next cycle.
- Timeout, with the macro defined. TIMEOUT_CYCLES=100, arm, send no traffic → timeout=1 at cycle 100 after arm, state DONE. Without the macro, timeout stays 0 throughout.
